// File: rtl/regfile_wr_arbiter_if.sv
// Purpose : bundle of the two write requesters, the regfile write port and the read/bypass path.
// Latency : none, this is wiring only.
// Backpressure : rdy0/rdy1 travel back to the requesters; the regfile side never stalls.
// Ports   : vld0/a0/d0/rdy0 = writeback requester, vld1/ax1/dx1/rdy1 = long-latency requester,
//           we3/a3/wd3 = regfile write port, a1/a2 + rf_rd1/rf_rd2 -> rd1/rd2 = bypassed reads.
interface regfile_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  vld0;
  logic [ADDR_WIDTH-1:0] a0;
  logic [DATA_WIDTH-1:0] d0;
  logic                  rdy0;

  logic                  vld1;
  logic [ADDR_WIDTH-1:0] ax1;
  logic [DATA_WIDTH-1:0] dx1;
  logic                  rdy1;

  logic                  we3;
  logic [ADDR_WIDTH-1:0] a3;
  logic [DATA_WIDTH-1:0] wd3;

  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [DATA_WIDTH-1:0] rf_rd1;
  logic [DATA_WIDTH-1:0] rf_rd2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // Environment side: requesters plus the register file itself.
  modport master (
    output vld0, a0, d0, vld1, ax1, dx1, a1, a2, rf_rd1, rf_rd2,
    input  rdy0, rdy1, we3, a3, wd3, rd1, rd2
  );

  // Arbiter side.
  modport slave (
    input  vld0, a0, d0, vld1, ax1, dx1, a1, a2, rf_rd1, rf_rd2,
    output rdy0, rdy1, we3, a3, wd3, rd1, rd2
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose : share the single regfile write port between writeback (priority) and a long-latency
//           unit, with a starvation guard that forces one long-latency grant after MAX_WAIT denials.
// Latency : a transfer in cycle N appears on we3/a3/wd3 in cycle N+1; rd1/rd2 bypass is combinational.
// Backpressure : rdy0/rdy1 are combinational grants; the write port itself never stalls.
// Ports   : clk, rst (async, active high); bus = regfile_wr_arbiter_if.slave (see interface file).
// MAX_WAIT must lie in 1..15 so that it fits the 4-bit wait counter.
module regfile_wr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wr_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  typedef enum logic {
    NORM  = 1'b0,
    FORCE = 1'b1
  } state_t;

  localparam logic [4:0] MAX_W = 5'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       we_q;
  wr_t        wr_q;

  logic       rdy0_c;
  logic       rdy1_c;
  logic       deny1;
  logic [4:0] cnt_inc;
  wr_t        win;

  always_comb begin
    rdy0_c  = 1'b0;
    rdy1_c  = 1'b0;
    deny1   = 1'b0;
    cnt_inc = {1'b0, wait_cnt} + 5'd1;
    win     = '0;

    // NORM: writeback always wins; FORCE: the long-latency unit owns the port for one grant.
    if (state == FORCE) begin
      rdy1_c = bus.vld1;
    end else begin
      rdy0_c = bus.vld0;
      rdy1_c = bus.vld1 & ~bus.vld0;
    end
    deny1 = bus.vld1 & ~rdy1_c;

    // rdy already implies vld, and at most one of them can be high.
    if (rdy1_c) begin
      win = '{addr: bus.ax1, data: bus.dx1};
    end else begin
      win = '{addr: bus.a0, data: bus.d0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NORM;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      wr_q     <= '0;
    end else begin
      // Register the winning write. Register 0 is hardwired, so its write is accepted but
      // never enabled. Without a transfer only the enable drops; address/data hold.
      if (rdy0_c || rdy1_c) begin
        we_q <= (win.addr != '0);
        wr_q <= win;
      end else begin
        we_q <= 1'b0;
      end

      case (state)
        NORM: begin
          if (deny1) begin
            if (wait_cnt != 4'hF) begin
              wait_cnt <= cnt_inc[3:0];
            end
            // The denial that brings the count to MAX_WAIT arms the forced grant.
            if (cnt_inc >= MAX_W) begin
              state <= FORCE;
            end
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        FORCE: begin
          wait_cnt <= 4'd0;
          // Leave after the forced grant, or if the requester withdrew (so we never hang).
          if (rdy1_c || !bus.vld1) begin
            state <= NORM;
          end
        end
        default: begin
          state    <= NORM;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.rdy0 = rdy0_c;
  assign bus.rdy1 = rdy1_c;
  assign bus.we3  = we_q;
  assign bus.a3   = wr_q.addr;
  assign bus.wd3  = wr_q.data;

  // The regfile only holds the registered write from the following edge, so readers of that
  // address in the meantime see it through this bypass. Register 0 is never bypassed.
  assign bus.rd1 = (we_q && (wr_q.addr == bus.a1) && (bus.a1 != '0)) ? wr_q.data : bus.rf_rd1;
  assign bus.rd2 = (we_q && (wr_q.addr == bus.a2) && (bus.a2 != '0)) ? wr_q.data : bus.rf_rd2;

endmodule
